// File: rtl/up_down_counter_param.sv
// rtl/up_down_counter_param.sv - parameterised up/down counter with runtime limit, load and terminal count
module up_down_counter_param #(
    parameter int WIDTH    = 3,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_tc;
    logic             w_tc_nxt;

    always_comb begin
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        w_state_nxt = r_state;
        if (load) begin
            w_count_nxt = (load_val > max_val) ? max_val : load_val;
            w_state_nxt = ST_IDLE;
        end else if (en) begin
            w_state_nxt = up ? ST_UP : ST_DOWN;
            // A limit lowered under the current count snaps to the limit whatever the direction.
            if (r_count > max_val) begin
                w_count_nxt = max_val;
                w_tc_nxt    = 1'b1;
            end else if (up) begin
                if (r_count == max_val) begin
                    w_count_nxt = SATURATE ? max_val : '0;
                    w_tc_nxt    = 1'b1;
                end else begin
                    w_count_nxt = r_count + ONE;
                end
            end else begin
                if (r_count == '0) begin
                    w_count_nxt = SATURATE ? '0 : max_val;
                    w_tc_nxt    = 1'b1;
                end else begin
                    w_count_nxt = r_count - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_state <= ST_IDLE;
        end else begin
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
            r_state <= w_state_nxt;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign state = r_state;

endmodule
